// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and sizing helper for the register file slice.
package regfile_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    function automatic int num_regs(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/regfile_busy_tracker.sv
// regfile_busy_tracker: per-register pending-load scoreboard with set/clear/flush.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit ZERO_R0 = 1'b0,
    localparam int NUM_REGS = num_regs(ADDR_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                issue,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic                we_b,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic [NUM_REGS-1:0] busy_vec
);
    logic [NUM_REGS-1:0] set_vec, clr_vec;

    assign set_vec = (issue && !(ZERO_R0 && issue_addr == '0)) ? NUM_REGS'(1) << issue_addr : '0;
    assign clr_vec = we_b ? NUM_REGS'(1) << wb_addr : '0;

    // set is applied after clear so a same-cycle re-issue keeps the register pending
    always_ff @(posedge clk or posedge rst)
        if (rst) busy_vec <= '0;
        else if (clr) busy_vec <= '0;
        else busy_vec <= (busy_vec & ~clr_vec) | set_vec;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: dual-write-port register file with bypass, optional zero R0
// and a pending-load busy scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit ZERO_R0 = 1'b0,
    parameter bit BYPASS = 1'b1,
    localparam int NUM_REGS = num_regs(ADDR_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [ADDR_W-1:0]   s1_addr,
    input  logic [ADDR_W-1:0]   s2_addr,
    output logic [DATA_W-1:0]   d_data,
    output logic [DATA_W-1:0]   s1_data,
    output logic [DATA_W-1:0]   s2_data,
    output logic                d_busy,
    output logic                s1_busy,
    output logic                s2_busy,
    output logic [NUM_REGS-1:0] busy_vec,
    input  logic                we_a,
    input  logic [ADDR_W-1:0]   wa_addr,
    input  logic [DATA_W-1:0]   wa_data,
    input  logic                we_b,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                issue,
    input  logic [ADDR_W-1:0]   issue_addr
);
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] ra [3];
    logic [DATA_W-1:0] rdat [3];
    logic              rbsy [3];
    logic              wa_en, wb_en, fwd_a, fwd_b;

    assign wa_en = we_a && !clr && !(ZERO_R0 && wa_addr == '0);
    assign wb_en = we_b && !clr && !(ZERO_R0 && wb_addr == '0);
    // no forwarding while in reset so every output reads zero immediately
    assign fwd_a = BYPASS && wa_en && !rst;
    assign fwd_b = BYPASS && wb_en && !rst;

    // port A is written last so it wins an address collision
    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        else if (clr) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        else begin
            if (wb_en) regs[wb_addr] <= wb_data;
            if (wa_en) regs[wa_addr] <= wa_data;
        end

    regfile_busy_tracker #(.ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_busy (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .issue(issue),
        .issue_addr(issue_addr),
        .we_b(we_b),
        .wb_addr(wb_addr),
        .busy_vec(busy_vec)
    );

    assign ra = '{d_addr, s1_addr, s2_addr};

    always_comb
        for (int i = 0; i < 3; i++) begin
            rdat[i] = (fwd_a && wa_addr == ra[i]) ? wa_data :
                      (fwd_b && wb_addr == ra[i]) ? wb_data : regs[ra[i]];
            rbsy[i] = busy_vec[ra[i]] && !(fwd_b && wb_addr == ra[i]);
        end

    assign d_data  = rdat[0];
    assign s1_data = rdat[1];
    assign s2_data = rdat[2];
    assign d_busy  = rbsy[0];
    assign s1_busy = rbsy[1];
    assign s2_busy = rbsy[2];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vector table plus reset corner sequences.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst, clr;
    logic [3:0]  d_addr, s1_addr, s2_addr, wa_addr, wb_addr, issue_addr;
    logic [15:0] d_data, s1_data, s2_data, wa_data, wb_data, busy_vec;
    logic        d_busy, s1_busy, s2_busy, we_a, we_b, issue;
    int          n_cmp = 0;
    int          n_bad = 0;

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .d_addr(d_addr), .s1_addr(s1_addr), .s2_addr(s2_addr),
        .d_data(d_data), .s1_data(s1_data), .s2_data(s2_data),
        .d_busy(d_busy), .s1_busy(s1_busy), .s2_busy(s2_busy),
        .busy_vec(busy_vec),
        .we_a(we_a), .wa_addr(wa_addr), .wa_data(wa_data),
        .we_b(we_b), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue(issue), .issue_addr(issue_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr, wa, wb, is;
        logic [3:0]  waa, wba, ia, d, s1, s2;
        logic [15:0] wad, wbd;
        logic [15:0] ed, es1, es2;
        logic        edb, es1b, es2b;
        logic [15:0] ebv;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(
        input logic c, input logic wa, input logic [3:0] waa, input logic [15:0] wad,
        input logic wb, input logic [3:0] wba, input logic [15:0] wbd,
        input logic is, input logic [3:0] ia,
        input logic [3:0] d, input logic [15:0] ed, input logic edb,
        input logic [3:0] s1, input logic [15:0] es1, input logic es1b,
        input logic [3:0] s2, input logic [15:0] es2, input logic es2b,
        input logic [15:0] ebv);
        vec_t v;
        v.clr = c; v.wa = wa; v.waa = waa; v.wad = wad;
        v.wb = wb; v.wba = wba; v.wbd = wbd; v.is = is; v.ia = ia;
        v.d = d; v.ed = ed; v.edb = edb;
        v.s1 = s1; v.es1 = es1; v.es1b = es1b;
        v.s2 = s2; v.es2 = es2; v.es2b = es2b;
        v.ebv = ebv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        clr = 0; we_a = 0; we_b = 0; issue = 0;
        wa_addr = 0; wb_addr = 0; issue_addr = 0; wa_data = 0; wb_data = 0;
    endtask

    task automatic apply(input int k, input vec_t v);
        @(negedge clk);
        clr = v.clr; we_a = v.wa; wa_addr = v.waa; wa_data = v.wad;
        we_b = v.wb; wb_addr = v.wba; wb_data = v.wbd;
        issue = v.is; issue_addr = v.ia;
        d_addr = v.d; s1_addr = v.s1; s2_addr = v.s2;
        #1;
        check($sformatf("v%0d d_data", k), 32'(d_data), 32'(v.ed));
        check($sformatf("v%0d s1_data", k), 32'(s1_data), 32'(v.es1));
        check($sformatf("v%0d s2_data", k), 32'(s2_data), 32'(v.es2));
        check($sformatf("v%0d d_busy", k), 32'(d_busy), 32'(v.edb));
        check($sformatf("v%0d s1_busy", k), 32'(s1_busy), 32'(v.es1b));
        check($sformatf("v%0d s2_busy", k), 32'(s2_busy), 32'(v.es2b));
        @(posedge clk);
        #1;
        check($sformatf("v%0d busy_vec", k), 32'(busy_vec), 32'(v.ebv));
    endtask

    initial begin
        //              clr wa waa wad       wb wba wbd       is ia  d  ed        db s1 es1       b  s2 es2       b  bv
        tbl[0]  = mk(0, 1, 3, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 3, 16'hBEEF, 0, 3, 16'hBEEF, 0, 16'h0000);
        tbl[1]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 3, 16'hBEEF, 0, 3, 16'hBEEF, 0, 5, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(0, 1, 5, 16'h1111, 1, 5, 16'h2222, 0, 0, 3, 16'hBEEF, 0, 5, 16'h1111, 0, 5, 16'h1111, 0, 16'h0000);
        tbl[3]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 16'h1111, 0, 5, 16'h1111, 0, 3, 16'hBEEF, 0, 16'h0000);
        tbl[4]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7, 7, 16'h0000, 0, 7, 16'h0000, 0, 7, 16'h0000, 0, 16'h0080);
        tbl[5]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 7, 16'h0000, 1, 7, 16'h0000, 1, 7, 16'h0000, 1, 16'h0080);
        tbl[6]  = mk(0, 0, 0, 16'h0000, 1, 7, 16'h00AA, 0, 0, 7, 16'h00AA, 0, 7, 16'h00AA, 0, 7, 16'h00AA, 0, 16'h0000);
        tbl[7]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 7, 16'h00AA, 0, 3, 16'hBEEF, 0, 7, 16'h00AA, 0, 16'h0000);
        tbl[8]  = mk(0, 0, 0, 16'h0000, 1, 7, 16'h0055, 1, 7, 7, 16'h0055, 0, 7, 16'h0055, 0, 7, 16'h0055, 0, 16'h0080);
        tbl[9]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 7, 16'h0055, 1, 7, 16'h0055, 1, 5, 16'h1111, 0, 16'h0080);
        tbl[10] = mk(0, 1, 0, 16'hFFFF, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 7, 16'h0055, 1, 16'h0080);
        tbl[11] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 7, 16'h0055, 1, 0, 16'h0000, 0, 7, 16'h0055, 1, 16'h0080);
        tbl[12] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 4, 4, 16'h0000, 0, 4, 16'h0000, 0, 7, 16'h0055, 1, 16'h0090);
        tbl[13] = mk(1, 1, 2, 16'h1234, 0, 0, 16'h0000, 1, 4, 4, 16'h0000, 1, 3, 16'hBEEF, 0, 7, 16'h0055, 1, 16'h0000);
        tbl[14] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 7, 16'h0000, 0, 2, 16'h0000, 0, 3, 16'h0000, 0, 16'h0000);

        rst = 1; idle(); d_addr = 0; s1_addr = 0; s2_addr = 0;
        #2;
        check("reset busy_vec", 32'(busy_vec), 32'h0);
        check("reset s1_data", 32'(s1_data), 32'h0);
        @(negedge clk);
        rst = 0;

        for (int k = 0; k < 15; k++) apply(k, tbl[k]);

        // populate state, then hit rst mid-cycle while a write is in flight
        @(negedge clk);
        we_a = 1; wa_addr = 3; wa_data = 16'hBEEF; issue = 1; issue_addr = 6;
        @(negedge clk);
        we_a = 1; wa_addr = 8; wa_data = 16'h5555; issue = 0;
        s1_addr = 3; s2_addr = 8; d_addr = 6;
        #1;
        check("pre-rst s1_data", 32'(s1_data), 32'hBEEF);
        check("pre-rst busy_vec", 32'(busy_vec), 32'h0040);
        #1 rst = 1;
        #1;
        check("async rst s1_data", 32'(s1_data), 32'h0);
        check("async rst s2_data", 32'(s2_data), 32'h0);
        check("async rst busy_vec", 32'(busy_vec), 32'h0);
        check("async rst d_busy", 32'(d_busy), 32'h0);
        @(negedge clk);
        idle();
        rst = 0;
        #1;
        check("post-rst R8 dropped", 32'(s2_data), 32'h0);
        check("post-rst R3", 32'(s1_data), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
